alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Command-driven sequencer for the 8-bit alu_control datapath. It replaces direct switch loading of A/B.
//  Commands (LOAD_A, LOAD_B, EXEC, EXEC_ACC) are queued in a small FIFO and replayed one at a time.
//  Operands and opcode are held stable toward the ALU, ALU_LAT cycles are waited, then result and flags
//  are captured and returned over a valid/ready channel. Sits between the tt_um top pins and alu_control.
// PARAMETERS
//  DEPTH    4  command FIFO entries (power of 2, >=2)
//  ALU_LAT  1  cycles from operands/opcode stable to result sample (>=1)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous reset, active low
//  ena          in   1  global enable; low freezes FIFO, FSM and all registers
//  cmd_valid    in   1  command offered
//  cmd_ready    out  1  command accepted when cmd_valid&cmd_ready
//  cmd_op       in   2  00 LOAD_A, 01 LOAD_B, 10 EXEC, 11 EXEC_ACC
//  cmd_data     in   8  operand for LOAD_A/LOAD_B (ignored otherwise)
//  cmd_ctl      in   3  ALU opcode for EXEC/EXEC_ACC
//  cmd_sh       in   3  shift amount for EXEC/EXEC_ACC
//  alu_a        out  8  operand A register to ALU
//  alu_b        out  8  operand B register to ALU
//  alu_ctl      out  3  opcode register to ALU
//  alu_sh       out  3  shift register to ALU (drives MovLeft/MovRight)
//  alu_res      in   8  ALU result
//  alu_flags    in   4  ALU flags
//  res_valid    out  1  result holding
//  res_ready    in   1  result consumed when res_valid&res_ready
//  res_data     out  8  captured result
//  res_flags    out  4  captured flags
//  busy         out  1  FSM not IDLE or FIFO non-empty
//  fifo_cnt     out  $clog2(DEPTH)+1  entries queued
// BEHAVIOUR
//  Reset: all registers, alu_*, res_*, fifo_cnt = 0; FSM=IDLE; cmd_ready=0 while rst_n low.
//  cmd_ready = ena & (fifo_cnt != DEPTH). Push and pop in the same cycle are allowed (count unchanged).
//  ena=0: no push (ready=0), no pop, no state/counter change; res_valid held, res_ready ignored.
//  FSM (all transitions are gated by ena):
//   IDLE: if fifo_cnt>0, pop head.
//     LOAD_A: alu_a<=data, stay IDLE. LOAD_B: alu_b<=data, stay IDLE.
//     Result: one load per cycle; alu_a/alu_b/alu_ctl/alu_sh hold value until rewritten.
//   IDLE: on EXEC/EXEC_ACC pop: alu_ctl<=ctl, alu_sh<=sh, wcnt<=ALU_LAT-1, go WAIT.
//   WAIT: if wcnt==0, res_data<=alu_res, res_flags<=alu_flags, res_valid<=1, go RESP;
//     additionally if EXEC_ACC, alu_a<=alu_res in that same cycle. Else wcnt<=wcnt-1.
//   RESP: while res_ready=0, hold all. On res_ready=1: res_valid<=0, go IDLE.
//     Next pop can occur the cycle after RESP exits.
//  Latency: EXEC popped at cycle t -> res_valid high at t+ALU_LAT+1 (empty queue, ena=1).
//  alu_a/alu_b/alu_ctl/alu_sh never change during WAIT or RESP.
//  FIFO keeps accepting during WAIT/RESP until full. Pointers wrap modulo DEPTH.
//  Reset mid-operation: immediate return to reset values; queued commands discarded.
//  Result at reset is never delivered.
//  cmd_op/data/ctl/sh are sampled only on an accepting handshake.
// TESTING (bench models ALU as alu_res=alu_a+alu_b, alu_flags={carry,3'b0})
//  1. LOAD_A 0x12, LOAD_B 0x34, EXEC ctl=0
//     -> res_valid at pop+2 (ALU_LAT=1); res_data=0x46, res_flags=0.
//  2. LOAD_A 0xF0, LOAD_B 0x20, EXEC_ACC, EXEC_ACC
//     -> results 0x10 (flags 4'b1000), then 0x30; alu_a=0x30 at end.
//  3. Push 5 commands with res_ready=0, DEPTH=4: 4th push -> cmd_ready=0 at fifo_cnt=4.
//     Pop in IDLE frees slot; simultaneous push+pop keeps count.
//  4. Hold res_ready=0 for 10 cycles in RESP -> res_data, alu_* and fifo_cnt stable; release -> IDLE next cycle.
//  5. Drop ena for 3 cycles mid-WAIT -> wcnt/state frozen, cmd_ready=0; result latency extends by exactly 3.
//  6. Assert rst_n=0 while RESP with 2 queued -> res_valid=0, fifo_cnt=0, alu_a=alu_b=0 immediately.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Command-driven front end for the 8-bit ALU datapath. LOAD_A,
//                LOAD_B, EXEC and EXEC_ACC commands are queued in a small FIFO
//                and replayed one at a time; operands and opcode are held
//                stable toward the ALU, ALU_LAT cycles are waited, then the
//                result and flags are returned over a valid/ready channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [7:0]               cmd_data,
    input  logic [2:0]               cmd_ctl,
    input  logic [2:0]               cmd_sh,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic [2:0]               alu_ctl,
    output logic [2:0]               alu_sh,
    input  logic [7:0]               alu_res,
    input  logic [3:0]               alu_flags,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_data,
    output logic [3:0]               res_flags,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int c_aw  = $clog2(DEPTH);
    localparam int c_cw  = c_aw + 1;
    localparam int c_wcw = $clog2(ALU_LAT + 1);

    localparam logic [c_cw-1:0]  c_depth = c_cw'(DEPTH);
    localparam logic [c_wcw-1:0] c_wlat  = c_wcw'(ALU_LAT - 1);

    localparam logic [1:0] c_OP_LOAD_A = 2'b00;
    localparam logic [1:0] c_OP_LOAD_B = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Queue storage: {op[1:0], data[7:0], ctl[2:0], sh[2:0]}
    logic [15:0]      r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_cw-1:0]  r_cnt;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_wcw-1:0] r_wcnt;
    logic             r_acc;

    logic [7:0]       r_alu_a;
    logic [7:0]       r_alu_b;
    logic [2:0]       r_alu_ctl;
    logic [2:0]       r_alu_sh;
    logic             r_res_valid;
    logic [7:0]       r_res_data;
    logic [3:0]       r_res_flags;

    logic             w_push;
    logic             w_pop;
    logic             w_capture;
    logic             w_release;
    logic [15:0]      w_head;
    logic [1:0]       w_head_op;
    logic [7:0]       w_head_data;
    logic [2:0]       w_head_ctl;
    logic [2:0]       w_head_sh;

    assign w_head      = r_mem[r_rptr];
    assign w_head_op   = w_head[15:14];
    assign w_head_data = w_head[13:6];
    assign w_head_ctl  = w_head[5:3];
    assign w_head_sh   = w_head[2:0];

    // Reset gating keeps the upstream from seeing a ready while held in reset
    assign cmd_ready = ena & rst_n & (r_cnt != c_depth);
    assign w_push    = cmd_valid & cmd_ready;
    // Only IDLE consumes commands, so loads retire one per cycle
    assign w_pop     = ena & (r_state == S_IDLE) & (r_cnt != '0);

    // FIFO storage, pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {cmd_op, cmd_data, cmd_ctl, cmd_sh};
                r_wptr        <= r_wptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_cw'(1);
                2'b01:   r_cnt <= r_cnt - c_cw'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and datapath strobes; everything holds while ena is low
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop && w_head_op[1]) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wcnt == '0) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_RESP;
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        w_release   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Operand/opcode registers, latency counter and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_ctl   <= '0;
            r_alu_sh    <= '0;
            r_wcnt      <= '0;
            r_acc       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_flags <= '0;
        end else if (ena) begin
            if (w_pop) begin
                case (w_head_op)
                    c_OP_LOAD_A: r_alu_a <= w_head_data;
                    c_OP_LOAD_B: r_alu_b <= w_head_data;
                    default: begin
                        r_alu_ctl <= w_head_ctl;
                        r_alu_sh  <= w_head_sh;
                        r_acc     <= w_head_op[0];
                        r_wcnt    <= c_wlat;
                    end
                endcase
            end
            if (r_state == S_WAIT) begin
                if (w_capture) begin
                    r_res_data  <= alu_res;
                    r_res_flags <= alu_flags;
                    r_res_valid <= 1'b1;
                    // Accumulate: the result becomes the next A operand
                    if (r_acc) begin
                        r_alu_a <= alu_res;
                    end
                end else begin
                    r_wcnt <= r_wcnt - c_wcw'(1);
                end
            end
            if (w_release) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_ctl   = r_alu_ctl;
    assign alu_sh    = r_alu_sh;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_flags = r_res_flags;
    assign busy      = (r_state != S_IDLE) | (r_cnt != '0);
    assign fifo_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Self-checking bench for alu_cmd_sequencer with an adder ALU
//                model and a transaction-level reference of expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [2:0] cmd_ctl;
    logic [2:0] cmd_sh;
    logic [7:0] alu_a, alu_b, alu_res, res_data;
    logic [2:0] alu_ctl, alu_sh;
    logic [3:0] alu_flags, res_flags;
    logic       res_valid, res_ready, busy;
    logic [2:0] fifo_cnt;
    logic [8:0] w_sum;

    always #5 clk = ~clk;

    // ALU model: adder with carry out in the top flag bit
    assign w_sum     = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_res   = w_sum[7:0];
    assign alu_flags = {w_sum[8], 3'b000};

    alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_ctl(cmd_ctl), .cmd_sh(cmd_sh),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_sh(alu_sh),
        .alu_res(alu_res), .alu_flags(alu_flags),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_flags(res_flags), .busy(busy), .fifo_cnt(fifo_cnt)
    );

    typedef struct {
        logic [7:0] res;
        logic [3:0] flags;
    } exp_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    exp_t       exp_q[$];
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: commands take effect in acceptance order
    task automatic model_cmd(input logic [1:0] op, input logic [7:0] d);
        logic [8:0] s;
        case (op)
            2'd0: m_a = d;
            2'd1: m_b = d;
            default: begin
                s = {1'b0, m_a} + {1'b0, m_b};
                exp_q.push_back('{res: s[7:0], flags: {s[8], 3'b000}});
                if (op == 2'd3) m_a = s[7:0];
            end
        endcase
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] d,
                        input logic [2:0] ctl, input logic [2:0] sh);
        bit acc = 1'b0;
        int n   = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_ctl = ctl; cmd_sh = sh;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = cmd_ready;
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        check("push_accept", 32'(acc), 32'd1);
        if (acc) model_cmd(op, d);
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        while (!res_valid && cyc < budget) begin
            tick();
            cyc++;
        end
        check("wait_valid", 32'(res_valid), 32'd1);
    endtask

    task automatic take_result(input string tag);
        exp_t e;
        check({tag, "_pending"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 32'(res_data), 32'(e.res));
            check({tag, "_flags"}, 32'(res_flags), 32'(e.flags));
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_released"}, 32'(res_valid), 32'd0);
    endtask

    // One randomized cycle: score any handshakes that happen at the next edge
    task automatic step_scored();
        bit   acc, rsp;
        exp_t e;
        @(negedge clk);
        check("rnd_ready", 32'(cmd_ready), 32'(ena && fifo_cnt != 3'd4));
        acc = cmd_valid && cmd_ready;
        rsp = ena && res_valid && res_ready;
        if (rsp) begin
            check("rnd_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rnd_data", 32'(res_data), 32'(e.res));
                check("rnd_flags", 32'(res_flags), 32'(e.flags));
            end
        end
        if (acc) model_cmd(cmd_op, cmd_data);
        tick();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
        cmd_ctl = '0; cmd_sh = '0; res_ready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_cnt", 32'(fifo_cnt), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        // 1: plain EXEC, latency ALU_LAT+1 after the pop cycle
        push(2'd0, 8'h12, 3'd0, 3'd0);
        push(2'd1, 8'h34, 3'd0, 3'd0);
        push(2'd2, 8'h00, 3'd5, 3'd2);
        wait_valid(20, cyc);
        check("t1_latency", 32'(cyc), 32'd2);
        check("t1_ctl", 32'(alu_ctl), 32'd5);
        check("t1_sh", 32'(alu_sh), 32'd2);
        check("t1_const", 32'(res_data), 32'h46);
        take_result("t1");

        // 2: accumulate twice, first with carry
        push(2'd0, 8'hF0, 3'd0, 3'd0);
        push(2'd1, 8'h20, 3'd0, 3'd0);
        push(2'd3, 8'h00, 3'd1, 3'd0);
        push(2'd3, 8'h00, 3'd1, 3'd0);
        wait_valid(20, cyc);
        check("t2a_flags_const", 32'(res_flags), 32'h8);
        take_result("t2a");
        wait_valid(20, cyc);
        take_result("t2b");
        check("t2_alu_a", 32'(alu_a), 32'h30);
        check("t2_alu_b", 32'(alu_b), 32'h20);

        // 3: fill the queue while the result is held, then push+pop together
        push(2'd2, 8'h00, 3'd0, 3'd0);
        wait_valid(20, cyc);
        push(2'd0, 8'h07, 3'd0, 3'd0);
        check("t3_cnt1", 32'(fifo_cnt), 32'd1);
        push(2'd1, 8'h09, 3'd0, 3'd0);
        check("t3_cnt2", 32'(fifo_cnt), 32'd2);
        push(2'd2, 8'h00, 3'd0, 3'd0);
        check("t3_cnt3", 32'(fifo_cnt), 32'd3);
        push(2'd0, 8'h0A, 3'd0, 3'd0);
        check("t3_cnt4", 32'(fifo_cnt), 32'd4);
        check("t3_full_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 8'h00;
        tick();
        check("t3_hold_cnt", 32'(fifo_cnt), 32'd4);
        take_result("t3x");
        check("t3_full_idle", 32'(cmd_ready), 32'd0);
        tick();
        check("t3_pop_cnt", 32'(fifo_cnt), 32'd3);
        check("t3_pop_a", 32'(alu_a), 32'h07);
        tick();
        check("t3_pushpop_cnt", 32'(fifo_cnt), 32'd3);
        check("t3_pushpop_b", 32'(alu_b), 32'h09);
        cmd_valid = 1'b0;
        model_cmd(2'd2, 8'h00);
        wait_valid(20, cyc);
        take_result("t3a");
        wait_valid(20, cyc);
        check("t3b_const", 32'(res_data), 32'h13);
        take_result("t3b");

        // 4: hold the result for 10 cycles with a load queued behind it
        push(2'd0, 8'h55, 3'd0, 3'd0);
        push(2'd1, 8'h66, 3'd0, 3'd0);
        push(2'd2, 8'h00, 3'd0, 3'd0);
        push(2'd0, 8'h01, 3'd0, 3'd0);
        wait_valid(20, cyc);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_valid", 32'(res_valid), 32'd1);
            check("t4_data", 32'(res_data), 32'hBB);
            check("t4_alu_a", 32'(alu_a), 32'h55);
            check("t4_cnt", 32'(fifo_cnt), 32'd1);
        end
        take_result("t4");
        tick();
        check("t4_next_pop_a", 32'(alu_a), 32'h01);
        check("t4_next_pop_cnt", 32'(fifo_cnt), 32'd0);

        // 5: freeze for 3 cycles in WAIT
        push(2'd2, 8'h00, 3'd0, 3'd0);
        tick();
        ena = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 8'hAA;
        #1;
        check("t5_ready_frozen", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_valid_frozen", 32'(res_valid), 32'd0);
            check("t5_cnt_frozen", 32'(fifo_cnt), 32'd0);
        end
        cmd_valid = 1'b0;
        ena = 1'b1;
        tick();
        check("t5_valid_late", 32'(res_valid), 32'd1);
        take_result("t5");

        // 6: asynchronous reset while holding a result with 2 queued
        push(2'd0, 8'h11, 3'd0, 3'd0);
        push(2'd1, 8'h22, 3'd0, 3'd0);
        push(2'd2, 8'h00, 3'd0, 3'd0);
        push(2'd0, 8'h33, 3'd0, 3'd0);
        push(2'd1, 8'h44, 3'd0, 3'd0);
        wait_valid(20, cyc);
        check("t6_cnt_before", 32'(fifo_cnt), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(res_valid), 32'd0);
        check("t6_cnt", 32'(fifo_cnt), 32'd0);
        check("t6_alu_a", 32'(alu_a), 32'd0);
        check("t6_alu_b", 32'(alu_b), 32'd0);
        check("t6_ready", 32'(cmd_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        m_a = 8'h00; m_b = 8'h00;
        exp_q.delete();
        tick(); tick();
        check("t6_no_delivery", 32'(res_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 500; i++) begin
            ena       = ($urandom_range(0, 9) != 0);
            cmd_valid = $urandom_range(0, 1);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_data  = 8'($urandom);
            cmd_ctl   = 3'($urandom);
            cmd_sh    = 3'($urandom);
            res_ready = ($urandom_range(0, 2) == 0);
            step_scored();
        end
        cmd_valid = 1'b0; ena = 1'b1; res_ready = 1'b1;
        for (int i = 0; i < 200 && (busy || res_valid); i++) begin
            step_scored();
        end
        res_ready = 1'b0;
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_cnt", 32'(fifo_cnt), 32'd0);
        check("drain_leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
